// File: rtl/delay_memory_responder.sv
// Memory-side responder for external_memory_if: captures per-sample write/read
// requests and replays them on a word-addressed Avalon-MM master port.
module delay_memory_responder #(
    parameter int unsigned DWIDTH         = 16,
    parameter int unsigned AWIDTH         = 16,
    parameter int unsigned MEM_AWIDTH     = 24,
    parameter logic [MEM_AWIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sample_tick_i,
    input  logic                  write_enable_i,
    input  logic [AWIDTH-1:0]     write_address_i,
    input  logic [DWIDTH-1:0]     writedata_i,
    input  logic [AWIDTH-1:0]     read_address_i,
    output logic [DWIDTH-1:0]     readdata_o,
    output logic [MEM_AWIDTH-1:0] avm_address_o,
    output logic                  avm_write_o,
    output logic                  avm_read_o,
    output logic [DWIDTH-1:0]     avm_writedata_o,
    input  logic                  avm_waitrequest_i,
    input  logic [DWIDTH-1:0]     avm_readdata_i,
    input  logic                  avm_readdatavalid_i,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_S,
        WRITE_S,
        READ_S,
        WAIT_S
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt;
    logic [AWIDTH-1:0]     wr_addr_q;
    logic [DWIDTH-1:0]     wr_data_q;
    logic [AWIDTH-1:0]     rd_addr_q;

    logic capture, cnt_clr, rd_load, rd_abort, to_set, expired;

    function automatic logic [MEM_AWIDTH-1:0] map_addr(input logic [AWIDTH-1:0] a);
        return BASE_ADDR + MEM_AWIDTH'(a);
    endfunction

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE_S;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d         = state;
        capture         = 1'b0;
        cnt_clr         = 1'b0;
        rd_load         = 1'b0;
        rd_abort        = 1'b0;
        to_set          = 1'b0;
        avm_write_o     = 1'b0;
        avm_read_o      = 1'b0;
        avm_address_o   = '0;
        avm_writedata_o = '0;
        case (state)
            IDLE_S: begin
                cnt_clr = 1'b1;
                if (sample_tick_i) begin
                    capture = 1'b1;
                    state_d = write_enable_i ? WRITE_S : READ_S;
                end
            end
            WRITE_S: begin
                avm_write_o     = 1'b1;
                avm_address_o   = map_addr(wr_addr_q);
                avm_writedata_o = wr_data_q;
                if (!avm_waitrequest_i) begin
                    cnt_clr = 1'b1;
                    state_d = READ_S;
                end else if (expired) begin
                    to_set  = 1'b1;
                    state_d = IDLE_S;
                end
            end
            READ_S: begin
                avm_read_o    = 1'b1;
                avm_address_o = map_addr(rd_addr_q);
                if (!avm_waitrequest_i) begin
                    // data may already be valid in the accept cycle
                    if (avm_readdatavalid_i) begin
                        rd_load = 1'b1;
                        state_d = IDLE_S;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = WAIT_S;
                    end
                end else if (expired) begin
                    to_set   = 1'b1;
                    rd_abort = 1'b1;
                    state_d  = IDLE_S;
                end
            end
            WAIT_S: begin
                if (avm_readdatavalid_i) begin
                    rd_load = 1'b1;
                    state_d = IDLE_S;
                end else if (expired) begin
                    to_set   = 1'b1;
                    rd_abort = 1'b1;
                    state_d  = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt        <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            readdata_o <= '0;
            overrun_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (capture) begin
                wr_addr_q <= write_address_i;
                wr_data_q <= writedata_i;
                rd_addr_q <= read_address_i;
            end
            // an aborted read mutes the output instead of repeating stale audio
            if (rd_load) begin
                readdata_o <= avm_readdata_i;
            end else if (rd_abort) begin
                readdata_o <= '0;
            end
            if (to_set) begin
                timeout_o <= 1'b1;
            end
            if (sample_tick_i && state != IDLE_S) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_memory_responder.sv
// Directed bench for delay_memory_responder with a scripted Avalon-MM slave
// (configurable wait states and read latency).
module tb_delay_memory_responder;

    logic        clk_i;
    logic        rstn_i;
    logic        sample_tick_i;
    logic        write_enable_i;
    logic [15:0] write_address_i;
    logic [15:0] writedata_i;
    logic [15:0] read_address_i;
    logic [15:0] readdata_o;
    logic [23:0] avm_address_o;
    logic        avm_write_o;
    logic        avm_read_o;
    logic [15:0] avm_writedata_o;
    logic        avm_waitrequest_i;
    logic [15:0] avm_readdata_i;
    logic        avm_readdatavalid_i;
    logic        overrun_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    // slave configuration, set by the main sequence
    int wr_ws    = 0;
    int rd_ws    = 0;
    int rd_lat   = 0;
    bit rd_never = 0;

    logic [15:0] mem [256];
    int          busy_cnt  = 0;
    bit          pend_on   = 0;
    int          pend_cnt  = 0;
    logic [15:0] pend_data = '0;

    delay_memory_responder #(
        .DWIDTH        (16),
        .AWIDTH        (16),
        .MEM_AWIDTH    (24),
        .BASE_ADDR     (24'hFFFFF0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .sample_tick_i      (sample_tick_i),
        .write_enable_i     (write_enable_i),
        .write_address_i    (write_address_i),
        .writedata_i        (writedata_i),
        .read_address_i     (read_address_i),
        .readdata_o         (readdata_o),
        .avm_address_o      (avm_address_o),
        .avm_write_o        (avm_write_o),
        .avm_read_o         (avm_read_o),
        .avm_writedata_o    (avm_writedata_o),
        .avm_waitrequest_i  (avm_waitrequest_i),
        .avm_readdata_i     (avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i),
        .overrun_o          (overrun_o),
        .timeout_o          (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Avalon slave: decides waitrequest/readdatavalid just after each rising edge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        avm_waitrequest_i   = 1'b0;
        avm_readdatavalid_i = 1'b0;
        avm_readdata_i      = '0;
        forever begin
            @(posedge clk_i);
            #1;
            avm_readdatavalid_i = 1'b0;
            avm_waitrequest_i   = 1'b0;
            if (pend_on) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid_i = 1'b1;
                    avm_readdata_i      = pend_data;
                    pend_on             = 0;
                end
            end
            if (avm_write_o || avm_read_o) begin
                if (busy_cnt < (avm_write_o ? wr_ws : rd_ws)) begin
                    avm_waitrequest_i = 1'b1;
                    busy_cnt++;
                end else begin
                    busy_cnt = 0;
                    if (avm_write_o) begin
                        mem[avm_address_o[7:0]] = avm_writedata_o;
                    end else if (!rd_never) begin
                        if (rd_lat == 0) begin
                            avm_readdatavalid_i = 1'b1;
                            avm_readdata_i      = mem[avm_address_o[7:0]];
                        end else begin
                            pend_on   = 1;
                            pend_cnt  = rd_lat;
                            pend_data = mem[avm_address_o[7:0]];
                        end
                    end
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // called at a falling edge; returns one falling edge after the tick is sampled
    task automatic tick(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                        input logic [15:0] ra);
        write_enable_i  = we;
        write_address_i = wa;
        writedata_i     = wd;
        read_address_i  = ra;
        sample_tick_i   = 1'b1;
        @(negedge clk_i);
        sample_tick_i   = 1'b0;
    endtask

    initial begin
        rstn_i          = 1'b0;
        sample_tick_i   = 1'b0;
        write_enable_i  = 1'b0;
        write_address_i = '0;
        writedata_i     = '0;
        read_address_i  = '0;

        // reset state
        step(1);
        chk("rst_readdata", readdata_o, 0);
        chk("rst_write", avm_write_o, 0);
        chk("rst_read", avm_read_o, 0);
        chk("rst_addr", avm_address_o, 0);
        chk("rst_wdata", avm_writedata_o, 0);
        chk("rst_flags", {overrun_o, timeout_o}, 0);
        rstn_i = 1'b1;
        step(3);

        // write then read of the same address, zero-latency bus
        tick(1'b1, 16'h0005, 16'h1234, 16'h0005);
        chk("t1_write", {avm_write_o, avm_read_o}, 2'b10);
        chk("t1_waddr", avm_address_o, 24'hFFFFF5);
        chk("t1_wdata", avm_writedata_o, 16'h1234);
        step(1);
        chk("t1_read", {avm_write_o, avm_read_o}, 2'b01);
        chk("t1_raddr", avm_address_o, 24'hFFFFF5);
        step(1);
        chk("t1_rdata", readdata_o, 16'h1234);
        chk("t1_idle", {avm_write_o, avm_read_o}, 2'b00);
        step(60);

        // address wrap: 0xFFFFF0 + 0x20 and 0xFFFFF0 + 0xFFFF modulo 2**24
        tick(1'b1, 16'h0020, 16'h5A5A, 16'hFFFF);
        chk("t2_waddr_wrap", avm_address_o, 24'h000010);
        step(1);
        chk("t2_raddr_wrap", avm_address_o, 24'h00FFEF);
        step(1);
        chk("t2_rdata_empty", readdata_o, 16'h0000);
        step(60);
        tick(1'b0, 16'h0000, 16'h0000, 16'h0020);
        chk("t3_read_only", {avm_write_o, avm_read_o}, 2'b01);
        chk("t3_raddr", avm_address_o, 24'h000010);
        step(1);
        chk("t3_rdata", readdata_o, 16'h5A5A);
        step(60);

        // ten wait states on the write
        wr_ws = 10;
        tick(1'b1, 16'h0007, 16'hC0DE, 16'h0007);
        for (int i = 0; i < 11; i++) begin
            chk("t4_hold_strobe", {avm_write_o, avm_read_o}, 2'b10);
            chk("t4_hold_addr", avm_address_o, 24'hFFFFF7);
            chk("t4_hold_data", avm_writedata_o, 16'hC0DE);
            step(1);
        end
        chk("t4_read_after", {avm_write_o, avm_read_o}, 2'b01);
        step(1);
        chk("t4_rdata", readdata_o, 16'hC0DE);
        chk("t4_no_overrun", overrun_o, 1'b0);
        wr_ws = 0;
        step(60);

        // tick period 8 against read latency 12
        rd_lat = 12;
        tick(1'b0, 16'h0000, 16'h0000, 16'h0005);
        step(6);
        chk("t5_pre_overrun", overrun_o, 1'b0);
        step(1);
        tick(1'b1, 16'h0009, 16'hFFFF, 16'h0020);
        chk("t5_overrun", overrun_o, 1'b1);
        chk("t5_ignored_write", avm_write_o, 1'b0);
        chk("t5_hold_old", readdata_o, 16'hC0DE);
        step(5);
        chk("t5_rdata", readdata_o, 16'h1234);
        step(2);
        chk("t5_idle", {avm_write_o, avm_read_o, timeout_o}, 3'b000);
        rd_lat = 0;
        step(60);

        // readdatavalid never arrives
        rd_never = 1;
        tick(1'b0, 16'h0000, 16'h0000, 16'h0005);
        step(9);
        chk("t6_pending", {readdata_o, timeout_o}, {16'h1234, 1'b0});
        step(8);
        chk("t6_read_low", avm_read_o, 1'b0);
        chk("t6_timeout", timeout_o, 1'b1);
        chk("t6_muted", readdata_o, 16'h0000);
        rd_never = 0;
        step(40);
        tick(1'b1, 16'h0030, 16'h7777, 16'h0030);
        chk("t6_next_write", {avm_write_o, avm_read_o}, 2'b10);
        chk("t6_next_addr", avm_address_o, 24'h000020);
        step(2);
        chk("t6_next_rdata", readdata_o, 16'h7777);
        chk("t6_sticky", {overrun_o, timeout_o}, 2'b11);
        step(60);

        // reset during the read wait, late readdatavalid afterwards
        rd_lat = 5;
        tick(1'b0, 16'h0000, 16'h0000, 16'h0030);
        step(1);
        rstn_i = 1'b0;
        #1;
        chk("t7_rst_rdata", readdata_o, 16'h0000);
        chk("t7_rst_strobes", {avm_write_o, avm_read_o}, 2'b00);
        chk("t7_rst_addr", avm_address_o, 24'h000000);
        chk("t7_rst_flags", {overrun_o, timeout_o}, 2'b00);
        step(1);
        rstn_i = 1'b1;
        step(6);
        chk("t7_late_ignored", readdata_o, 16'h0000);
        chk("t7_idle", {avm_write_o, avm_read_o}, 2'b00);
        rd_lat = 0;
        step(20);
        tick(1'b0, 16'h0000, 16'h0000, 16'h0030);
        step(1);
        chk("t7_recover", readdata_o, 16'h7777);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
